// File: rtl/wddl_round_sched.sv
// ---------------------------------------------------------------------------
// wddl_round_sched
//   Round scheduler for the iterative WDDL AES-128 core. Sequences the
//   precharge / evaluate phases every WDDL gate network needs, counts AES
//   rounds and drives the state-register load / capture strobes. Owns no data.
//
//   Handshake: start_i is a level sampled only in IDLE or DONE; a start seen
//   there launches exactly one block. done_o is a single-cycle pulse. abort_i
//   returns the scheduler to IDLE from any state without a done_o pulse.
//
//   Optional feature (macro WDDL_RAND_PRE_EN): an 8-bit Fibonacci LFSR
//   (taps 8,6,5,4) stretches every PRE phase by 0..3 cycles to add timing
//   jitter. With the macro undefined the LFSR logic is absent and the
//   latency is fixed at 2 + NUM_ROUNDS*(PRE_CYCLES+EVAL_CYCLES+1).
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start_i      in   start one block encryption
//   abort_i      in   synchronous abort, returns to IDLE
//   busy_o       out  high in LOAD, PRE, EVAL, CAPT
//   done_o       out  one-cycle pulse in DONE
//   prech_o      out  1 = precharge (rails forced 0), 0 = evaluate
//   load_o       out  load plaintext/key (LOAD only)
//   capt_o       out  capture round result (CAPT only)
//   round_o      out  current round, 0 in IDLE/LOAD
//   last_round_o out  final round while busy (MixColumns skipped)
//   o_dbg_state  out  encoded FSM state for observation
// ---------------------------------------------------------------------------
module wddl_round_sched #(
  parameter int unsigned NUM_ROUNDS  = 10,
  parameter int unsigned PRE_CYCLES  = 1,
  parameter int unsigned EVAL_CYCLES = 1,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       abort_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       prech_o,
  output logic       load_o,
  output logic       capt_o,
  output logic [3:0] round_o,
  output logic       last_round_o,
  output logic [2:0] o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_PRE  = 3'd2,
    S_EVAL = 3'd3,
    S_CAPT = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [3:0] ROUND_LAST = 4'(NUM_ROUNDS);
  localparam logic [3:0] PRE_LAST   = 4'(PRE_CYCLES - 1);
  localparam logic [3:0] EVAL_LAST  = 4'(EVAL_CYCLES - 1);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic [3:0] r_round;
  logic [3:0] w_pre_last;
  logic       w_in_phase;

`ifdef WDDL_RAND_PRE_EN
  // Jitter source. The extra precharge count is latched on PRE entry so the
  // terminal count stays stable for the whole phase. With jitter enabled the
  // terminal count PRE_CYCLES+2 must fit the 4-bit phase counter, so
  // PRE_CYCLES is limited to 13 in this build.
  logic [7:0] r_lfsr;
  logic [1:0] r_extra;
  logic [7:0] w_lfsr_step;
  logic [7:0] w_lfsr_upd;

  assign w_lfsr_step = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  // On a CAPT->PRE transition the jitter uses the freshly advanced value.
  assign w_lfsr_upd  = (r_state == S_CAPT) ? w_lfsr_step : r_lfsr;
  assign w_pre_last  = PRE_LAST + {2'b00, r_extra};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr  <= LFSR_SEED;
      r_extra <= 2'd0;
    end else begin
      // Advances on every CAPT cycle, including one cut short by abort.
      r_lfsr <= w_lfsr_upd;
      if (w_next == S_PRE && r_state != S_PRE) begin
        r_extra <= w_lfsr_upd[1:0];
      end
    end
  end
`else
  assign w_pre_last = PRE_LAST;
`endif

  // Next-state logic; abort overrides every other decision.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start_i) w_next = S_LOAD;
      S_LOAD: w_next = S_PRE;
      S_PRE:  if (r_cnt == w_pre_last) w_next = S_EVAL;
      S_EVAL: if (r_cnt == EVAL_LAST) w_next = S_CAPT;
      S_CAPT: w_next = (r_round == ROUND_LAST) ? S_DONE : S_PRE;
      S_DONE: w_next = start_i ? S_LOAD : S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (abort_i) begin
      w_next = S_IDLE;
    end
  end

  // The phase counter only runs inside the timed phases and restarts on
  // every state change, so it never wraps.
  assign w_in_phase = (r_state == S_PRE) || (r_state == S_EVAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_round <= 4'd0;
    end else begin
      r_state <= w_next;

      if (w_next != r_state || !w_in_phase) begin
        r_cnt <= 4'd0;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end

      // Round is 0 in IDLE/LOAD, 1 on leaving LOAD, +1 per CAPT->PRE,
      // and simply holds through DONE.
      if (w_next == S_IDLE || w_next == S_LOAD) begin
        r_round <= 4'd0;
      end else if (r_state == S_LOAD) begin
        r_round <= 4'd1;
      end else if (r_state == S_CAPT && w_next == S_PRE) begin
        r_round <= r_round + 4'd1;
      end
    end
  end

  // Moore outputs decoded from registered state only. prech_o drops only
  // in EVAL/CAPT, and both are always entered through PRE.
  always_comb begin
    busy_o       = (r_state == S_LOAD) || (r_state == S_PRE) ||
                   (r_state == S_EVAL) || (r_state == S_CAPT);
    done_o       = (r_state == S_DONE);
    prech_o      = !((r_state == S_EVAL) || (r_state == S_CAPT));
    load_o       = (r_state == S_LOAD);
    capt_o       = (r_state == S_CAPT);
    round_o      = r_round;
    last_round_o = busy_o && (r_round == ROUND_LAST);
    o_dbg_state  = r_state;
  end

endmodule

// File: tb/tb_wddl_round_sched.sv
// ---------------------------------------------------------------------------
// tb_wddl_round_sched
//   Bench for wddl_round_sched. dut uses default parameters, dut2 uses
//   NUM_ROUNDS=14, PRE_CYCLES=2, EVAL_CYCLES=3. Per-cycle expected output
//   vectors {busy,done,prech,load,capt,last,round[3:0]} are built from the
//   phase lengths (plus a reference LFSR when WDDL_RAND_PRE_EN is defined)
//   and pushed to exp_q before a block is launched, then popped and compared
//   one per clock.
// ---------------------------------------------------------------------------
module tb_wddl_round_sched;

`ifdef WDDL_RAND_PRE_EN
  localparam bit JIT = 1'b1;
`else
  localparam bit JIT = 1'b0;
`endif
  localparam logic [7:0] SEED   = 8'hA5;
  localparam logic [9:0] V_IDLE = 10'b0010000000;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       start1, abort1, start2, abort2;
  logic       busy1, done1, prech1, load1, capt1, last1;
  logic       busy2, done2, prech2, load2, capt2, last2;
  logic [3:0] round1, round2;
  logic [2:0] dbg1, dbg2;
  logic [9:0] vec1, vec2;

  assign vec1 = {busy1, done1, prech1, load1, capt1, last1, round1};
  assign vec2 = {busy2, done2, prech2, load2, capt2, last2, round2};

  wddl_round_sched #(.LFSR_SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start1), .abort_i(abort1),
    .busy_o(busy1), .done_o(done1), .prech_o(prech1), .load_o(load1),
    .capt_o(capt1), .round_o(round1), .last_round_o(last1), .o_dbg_state(dbg1)
  );

  wddl_round_sched #(.NUM_ROUNDS(14), .PRE_CYCLES(2), .EVAL_CYCLES(3),
                     .LFSR_SEED(SEED)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_i(start2), .abort_i(abort2),
    .busy_o(busy2), .done_o(done2), .prech_o(prech2), .load_o(load2),
    .capt_o(capt2), .round_o(round2), .last_round_o(last2), .o_dbg_state(dbg2)
  );

  // scoreboard
  logic [9:0] exp_q[$];
  logic [7:0] lfsr1, lfsr2;
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [9:0] mk(input bit busy, input bit done, input bit prech,
                                    input bit load, input bit capt, input bit last,
                                    input int r);
    return {busy, done, prech, load, capt, last, 4'(r)};
  endfunction

  task automatic push_idle(input int n);
    repeat (n) exp_q.push_back(V_IDLE);
  endtask

  // Expected vectors from LOAD up to DONE; ab>0 stops after CAPT of round ab.
  task automatic push_block(input int nr, input int p, input int e, input int ab,
                            inout logic [7:0] lfsr);
    exp_q.push_back(mk(1, 0, 1, 1, 0, 0, 0));
    for (int r = 1; r <= nr; r++) begin
      int extra;
      bit last;
      extra = JIT ? int'(lfsr[1:0]) : 0;
      last  = (r == nr);
      repeat (p + extra) exp_q.push_back(mk(1, 0, 1, 0, 0, last, r));
      repeat (e) exp_q.push_back(mk(1, 0, 0, 0, 0, last, r));
      exp_q.push_back(mk(1, 0, 0, 0, 1, last, r));
      if (JIT) lfsr = lfsr_step(lfsr);
      if (r == ab) return;
    end
    exp_q.push_back(mk(0, 1, 1, 0, 0, 0, nr));
  endtask

  // driver: raise start just before edge 0
  task automatic kick(input bit sel);
    @(negedge clk);
    if (sel) start2 = 1'b1;
    else     start1 = 1'b1;
  endtask

  // Pops one expectation per clock and compares it. mode selects the
  // reaction: 0 pulse, 1 start held for two blocks, 2 abort+start in DONE,
  // 3 abort in CAPT of round 7, 4 reset during EVAL of round 4.
  task automatic run_q(input bit sel, input int mode, input string name);
    int         cyc;
    int         dones;
    bit         rst_done;
    bit         st, ab;
    logic [9:0] v, obs;
    cyc = 0; dones = 0; rst_done = 1'b0;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      cyc++;
      v   = exp_q.pop_front();
      obs = sel ? vec2 : vec1;
      n_tests++;
      if (obs !== v) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, obs, v);
      end
      st = 1'b0;
      ab = 1'b0;
      case (mode)
        1: begin
          if (v[8]) dones++;
          st = (dones < 2);
        end
        2: if (v[8]) begin st = 1'b1; ab = 1'b1; end
        3: if (v[5] && v[3:0] == 4'd7) ab = 1'b1;
        4: if (!rst_done && v[9] && !v[7] && !v[5] && v[3:0] == 4'd4) begin
          rst_n = 1'b0;
          #1;
          n_tests++;
          if (vec1 !== V_IDLE) begin
            n_fail++;
            $display("FAIL reset_async: got %b expected %b", vec1, V_IDLE);
          end
          exp_q.delete();
          @(posedge clk);
          @(negedge clk);
          rst_n    = 1'b1;
          lfsr1    = SEED;
          lfsr2    = SEED;
          rst_done = 1'b1;
          push_idle(5);
        end
        default: ;
      endcase
      if (sel) begin start2 = st; abort2 = ab; end
      else     begin start1 = st; abort1 = ab; end
    end
    start1 = 1'b0; abort1 = 1'b0; start2 = 1'b0; abort2 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start1 = 1'b0; abort1 = 1'b0; start2 = 1'b0; abort2 = 1'b0;
    lfsr1 = SEED; lfsr2 = SEED;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (vec1 !== V_IDLE) begin
      n_fail++;
      $display("FAIL reset_dut: got %b expected %b", vec1, V_IDLE);
    end
    n_tests++;
    if (vec2 !== V_IDLE) begin
      n_fail++;
      $display("FAIL reset_dut2: got %b expected %b", vec2, V_IDLE);
    end
    @(negedge clk);
    rst_n = 1'b1;
    push_idle(3);
    run_q(1'b0, 0, "idle_after_reset");
  endtask

  task automatic test_single_block();
    push_block(10, 1, 1, 0, lfsr1);
    push_idle(3);
    kick(1'b0);
    run_q(1'b0, 0, "single_block");
  endtask

  task automatic test_back_to_back();
    push_block(10, 1, 1, 0, lfsr1);
    push_block(10, 1, 1, 0, lfsr1);
    push_idle(3);
    kick(1'b0);
    run_q(1'b0, 1, "back_to_back");
  endtask

  task automatic test_abort_done_start();
    push_block(10, 1, 1, 0, lfsr1);
    push_idle(4);
    kick(1'b0);
    run_q(1'b0, 2, "abort_in_done");
  endtask

  task automatic test_abort_round7();
    push_block(10, 1, 1, 7, lfsr1);
    push_idle(12);
    kick(1'b0);
    run_q(1'b0, 3, "abort_round7");
  endtask

  task automatic test_reset_mid_eval();
    push_block(10, 1, 1, 0, lfsr1);
    kick(1'b0);
    run_q(1'b0, 4, "reset_mid_eval");
  endtask

  task automatic test_params();
    push_block(14, 2, 3, 0, lfsr2);
    push_idle(3);
    kick(1'b1);
    run_q(1'b1, 0, "params_14r");
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_back_to_back();
    test_abort_done_start();
    test_abort_round7();
    test_reset_mid_eval();
    test_single_block();
    test_params();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wddl_round_sched.md
Name: wddl_round_sched

Overview:
- Round scheduler for the iterative WDDL AES-128 core.
- Sequences the precharge/evaluate phases that every WDDL gate network needs, counts AES rounds and drives the state-register load/capture strobes.
- Sits between the host start/done handshake and the WDDL datapath built from standard cells; owns no data.

Parameters:
NUM_ROUNDS, 10, AES rounds per block (1..15)
PRE_CYCLES, 1, base precharge cycles per round (1..15)
EVAL_CYCLES, 1, evaluate cycles per round before capture (1..15)
LFSR_SEED, 8'hA5, reset value of jitter LFSR (non-zero; used only with WDDL_RAND_PRE_EN)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start_i  input  1  start one block encryption; sampled in IDLE/DONE only
abort_i  input  1  synchronous abort; highest priority after reset
busy_o  output  1  high in LOAD, PRE, EVAL, CAPT
done_o  output  1  one-cycle pulse in DONE
prech_o  output  1  1 = WDDL precharge (all datapath rails forced 0), 0 = evaluate
load_o  output  1  load plaintext/key into state register (LOAD only)
capt_o  output  1  capture round result into state register (CAPT only)
round_o  output  4  current round, 0 in IDLE/LOAD, 1..NUM_ROUNDS during rounds
last_round_o  output  1  round_o == NUM_ROUNDS while busy (datapath skips MixColumns)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, prech_o=1, busy_o=0, done_o=0, load_o=0, capt_o=0, round_o=0, last_round_o=0, phase counter=0, LFSR=LFSR_SEED. Deassertion takes effect on the next clk edge.
- All outputs are Moore-decoded from registered state/counters. No combinational path from any input to any output.
- States: IDLE, LOAD, PRE, EVAL, CAPT, DONE.
- IDLE: prech_o=1. If start_i=1, go to LOAD. Otherwise stay.
- LOAD: one cycle, load_o=1, prech_o=1, round_o=0. Next state PRE with round_o=1.
- PRE: prech_o=1 for PRE_CYCLES cycles (plus jitter, see Optional Feature), counted by the phase counter. Then go to EVAL.
- EVAL: prech_o=0 for EVAL_CYCLES cycles. Then go to CAPT.
- CAPT: one cycle, capt_o=1, prech_o=0 so data is stable at capture.
  - If round_o==NUM_ROUNDS, go to DONE.
  - Otherwise round_o increments and next state is PRE.
- DONE: one cycle, done_o=1, busy_o=0, prech_o=1, round_o holds NUM_ROUNDS.
  - If start_i=1, go to LOAD (back-to-back blocks).
  - Otherwise go to IDLE with round_o=0.
- start_i is ignored in LOAD, PRE, EVAL and CAPT.
- abort_i=1 in any state:
  - Next state is IDLE, round_o=0, phase counter cleared.
  - No done_o pulse.
  - abort wins over a simultaneous start_i.
  - The LFSR is not reset.
- Latency with defaults, start_i sampled at edge 0:
  - LOAD in cycle 1.
  - Round r occupies PRE=3r-1, EVAL=3r, CAPT=3r+1.
  - DONE in cycle 32.
  - In general: DONE cycle = 2 + NUM_ROUNDS*(PRE_CYCLES+EVAL_CYCLES+1).
- Phase counter is 4 bits wide. It is cleared on every state change and never wraps within a legal phase.
- prech_o is never 0 outside EVAL/CAPT. Every EVAL is preceded by at least one precharge cycle (WDDL invariant).

Optional Feature:
- Macro: WDDL_RAND_PRE_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; shifts left, feedback into bit 0) advances once per CAPT cycle.
  - Each PRE phase lasts PRE_CYCLES + LFSR[1:0] cycles (0..3 extra). The extra count is latched on entry to PRE.
  - Purpose: timing jitter against power analysis.
  - Total latency varies accordingly.
- Undefined:
  - The LFSR and its logic are absent.
  - PRE lasts exactly PRE_CYCLES.
  - Latency is the fixed formula above.

Test Plan:
- Reset mid-EVAL of round 4 (rst_n low 1 cycle) -> outputs immediately at reset values (prech_o=1, round_o=0, busy_o=0); block restarts only on a new start_i.
- Defaults, start_i pulse at cycle 0 -> load_o at cycle 1; capt_o at cycles 4,7,...,31 with round_o=1..10; last_round_o high cycles 29-31; done_o only at cycle 32; prech_o=0 only in cycles 3r, 3r+1.
- start_i held high continuously -> DONE at 32 goes directly to LOAD at 33; second done_o at cycle 64; start_i during busy has no effect.
- abort_i asserted together with start_i during DONE -> IDLE next cycle, no load_o; abort_i in round 7 CAPT -> no capt in round 8, done_o never pulses.
- PRE_CYCLES=2, EVAL_CYCLES=3, NUM_ROUNDS=14 -> done_o at cycle 2+14*6=86; every round has exactly 2 prech_o=1 then 4 prech_o=0 cycles.
- WDDL_RAND_PRE_EN defined, LFSR_SEED=8'hA5 -> PRE lengths match a reference LFSR model cycle-for-cycle; done cycle = 32 + sum of extras; never an EVAL without preceding precharge.
